// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU requester ports, the arbiter and the shared
// single-port word memory. The slave view belongs to the arbiter; the
// master view is the surrounding system (core requesters plus memory).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_wstrb;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-3:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and
// load/store. Data wins contested cycles until STREAK_MAX consecutive
// contested data grants have gone by, then fetch is forced through. Reads
// take the grant cycle plus one return cycle; stores finish in the grant cycle.
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_D = 2'd2
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [3:0]        streak;
  logic [DATA_W-1:0] if_hold;
  logic [DATA_W-1:0] d_hold;
  logic              grant_i;
  logic              grant_d;

  // Byte-offset bits of both requester addresses are deliberately ignored.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.d_addr[1:0]};

  // Arbitration in IDLE, memory strobes, and read-data steering to the owner.
  always_comb begin
    state_n       = state;
    grant_i       = 1'b0;
    grant_d       = 1'b0;
    bus.if_gnt    = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.if_rdata  = if_hold;
    bus.d_rdata   = d_hold;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    if (rst) begin
      state_n      = IDLE;
      bus.if_rdata = '0;
      bus.d_rdata  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.d_req && !(bus.if_req && streak == STREAK_LIM)) begin
            grant_d = 1'b1;
          end else if (bus.if_req) begin
            grant_i = 1'b1;
          end
          if (grant_d) begin
            bus.d_gnt    = 1'b1;
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.d_addr[ADDR_W-1:2];
            if (bus.d_we) begin
              bus.mem_we    = 1'b1;
              bus.mem_wdata = bus.d_wdata;
              bus.mem_wstrb = bus.d_wstrb;
            end else begin
              state_n = RD_D;
            end
          end else if (grant_i) begin
            bus.if_gnt   = 1'b1;
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.if_addr[ADDR_W-1:2];
            state_n      = RD_I;
          end
        end
        RD_I: begin
          bus.if_rvalid = 1'b1;
          bus.if_rdata  = bus.mem_rdata;
          state_n       = IDLE;
        end
        RD_D: begin
          bus.d_rvalid = 1'b1;
          bus.d_rdata  = bus.mem_rdata;
          state_n      = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Contested-data streak: counts data grants taken while fetch was waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (grant_d) begin
      if (!bus.if_req)              streak <= '0;
      else if (streak != STREAK_LIM) streak <= streak + 4'd1;
    end else if (grant_i) begin
      streak <= '0;
    end
  end

  // Held read data so each port keeps showing its last returned word.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_hold <= '0;
      d_hold  <= '0;
    end else if (state == RD_I) begin
      if_hold <= bus.mem_rdata;
    end else if (state == RD_D) begin
      d_hold <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a behavioural memory answers the DUT, a
// reference model predicts grants and read data from requests, and a
// separate monitor matches returned words against the expected queues.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int STREAK_MAX = 4;
  localparam int WORDS      = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STREAK_MAX(STREAK_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];
  logic [31:0] ifq[$];
  logic [31:0] dq[$];
  int          m_busy   = 0;   // 0 free, 1 load returning, 2 fetch returning
  int          m_streak = 0;
  logic [31:0] last_i   = '0;
  logic [31:0] last_d   = '0;
  logic        ig, dg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // Synchronous word memory with byte enables and one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we)
      for (int b = 0; b < 4; b++)
        if (bus.mem_wstrb[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Reference model: predicts grants and memory strobes each cycle.
  initial forever begin
    logic       ei, ed, een, ewe, eiv, edv, fetch_wins;
    logic [5:0] ea;
    logic [3:0] es;
    logic [31:0] ewd;
    @(negedge clk);
    ei = 0; ed = 0; een = 0; ewe = 0; eiv = 0; edv = 0; ea = '0; es = '0; ewd = '0;
    if (rst) begin
      if (m_busy == 1) void'(dq.pop_back());
      else if (m_busy == 2) void'(ifq.pop_back());
      m_busy = 0;
      m_streak = 0;
    end else if (m_busy != 0) begin
      eiv = (m_busy == 2);
      edv = (m_busy == 1);
      m_busy = 0;
    end else begin
      fetch_wins = bus.if_req && (!bus.d_req || m_streak == STREAK_MAX);
      if (bus.d_req && !fetch_wins) begin
        ed = 1; een = 1; ea = bus.d_addr[7:2];
        if (bus.d_we) begin
          ewe = 1; es = bus.d_wstrb; ewd = bus.d_wdata;
          for (int b = 0; b < 4; b++)
            if (bus.d_wstrb[b]) ref_mem[ea][8*b +: 8] = bus.d_wdata[8*b +: 8];
        end else begin
          dq.push_back(ref_mem[ea]);
          m_busy = 1;
        end
        if (!bus.if_req) m_streak = 0;
        else if (m_streak < STREAK_MAX) m_streak = m_streak + 1;
      end else if (fetch_wins) begin
        ei = 1; een = 1; ea = bus.if_addr[7:2];
        ifq.push_back(ref_mem[ea]);
        m_busy = 2;
        m_streak = 0;
      end
    end
    chk("if_gnt", 32'(bus.if_gnt), 32'(ei));
    chk("d_gnt", 32'(bus.d_gnt), 32'(ed));
    chk("mem_en", 32'(bus.mem_en), 32'(een));
    chk("mem_we", 32'(bus.mem_we), 32'(ewe));
    chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(es));
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(eiv));
    chk("d_rvalid", 32'(bus.d_rvalid), 32'(edv));
    if (een) chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
    if (ewe) chk("mem_wdata", bus.mem_wdata, ewd);
  end

  // Monitor: pops expected read data whenever a port presents rvalid.
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (rst) begin
      chk("rst_if_rdata", bus.if_rdata, 32'h0);
      chk("rst_d_rdata", bus.d_rdata, 32'h0);
      last_i = '0;
      last_d = '0;
    end else begin
      if (bus.if_rvalid) begin
        if (ifq.size() == 0) fail_now("if_rvalid_unexpected");
        else begin
          e = ifq.pop_front();
          chk("if_rdata", bus.if_rdata, e);
          last_i = e;
        end
      end else chk("if_rdata_hold", bus.if_rdata, last_i);
      if (bus.d_rvalid) begin
        if (dq.size() == 0) fail_now("d_rvalid_unexpected");
        else begin
          e = dq.pop_front();
          chk("d_rdata", bus.d_rdata, e);
          last_d = e;
        end
      end else chk("d_rdata_hold", bus.d_rdata, last_d);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic data_op(input logic we, input logic [7:0] a, input logic [31:0] wd,
                         input logic [3:0] st, output logic [31:0] rd);
    int n;
    rd = '0;
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; bus.d_wstrb = st;
    n = 0;
    @(negedge clk);
    while (!bus.d_gnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.d_gnt) fail_now("data_gnt_timeout");
    step();
    bus.d_req = 1'b0;
    if (!we) begin
      @(negedge clk);
      if (bus.d_rvalid) rd = bus.d_rdata;
      else fail_now("data_rvalid_missing");
      step();
    end
  endtask

  task automatic count_data_run(output int n, output logic got);
    n = 0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.if_gnt) got = 1'b1;
      else if (bus.d_gnt) n++;
      if (!got) step();
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          n;
    logic        got;
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
    for (int w = 0; w < WORDS; w++) begin
      mem[w] = $urandom;
      ref_mem[w] = mem[w];
    end
    mem[3] = 32'hDEADBEEF;
    ref_mem[3] = 32'hDEADBEEF;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Fetch-only read of word 3.
    bus.if_req = 1; bus.if_addr = 8'h0C;
    @(negedge clk);
    chk("t1_if_gnt", 32'(bus.if_gnt), 32'd1);
    chk("t1_mem_addr", 32'(bus.mem_addr), 32'd3);
    step();
    bus.if_req = 0;
    @(negedge clk);
    chk("t1_if_rdata", bus.if_rdata, 32'hDEADBEEF);
    chk("t1_no_gnt", 32'(bus.if_gnt), 32'd0);
    step();

    // Store, load back, partial store, reload.
    data_op(1'b1, 8'h10, 32'h12345678, 4'hF, rd);
    data_op(1'b0, 8'h10, 32'h0, 4'h0, rd);
    chk("t2_load", rd, 32'h12345678);
    data_op(1'b1, 8'h11, 32'h000000FF, 4'h1, rd);
    data_op(1'b0, 8'h13, 32'h0, 4'h0, rd);
    chk("t2_partial", rd, 32'h123456FF);

    // Contention: data stores against a waiting fetch.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.if_req = 1; bus.if_addr = 8'h20;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h30; bus.d_wdata = 32'hA5A5_0F0F; bus.d_wstrb = 4'hF;
    count_data_run(n, got);
    chk("t3_first_run", 32'(n), 32'd4);
    chk("t3_fetch_forced", 32'(got), 32'd1);
    step();
    count_data_run(n, got);
    chk("t3_second_run", 32'(n), 32'd4);
    chk("t3_fetch_forced2", 32'(got), 32'd1);
    step();
    bus.if_req = 0; bus.d_req = 0;
    step();

    // Simultaneous load and fetch.
    bus.if_req = 1; bus.if_addr = 8'h0C;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'h10;
    @(negedge clk);
    chk("t4_d_first", 32'({bus.d_gnt, bus.if_gnt}), 32'h2);
    step();
    bus.d_req = 0;
    @(negedge clk);
    chk("t4_d_rvalid", 32'({bus.d_rvalid, bus.if_gnt}), 32'h2);
    step();
    @(negedge clk);
    chk("t4_if_gnt", 32'(bus.if_gnt), 32'd1);
    step();
    bus.if_req = 0;
    @(negedge clk);
    chk("t4_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    step();
    @(negedge clk);
    chk("t4_if_hold", bus.if_rdata, 32'hDEADBEEF);
    step();

    // Reset during the fetch return cycle.
    bus.if_req = 1; bus.if_addr = 8'h14;
    @(negedge clk);
    chk("t5_gnt", 32'(bus.if_gnt), 32'd1);
    step();
    bus.if_req = 0; rst = 1;
    @(negedge clk);
    chk("t5_rvalid_in_rst", 32'(bus.if_rvalid), 32'd0);
    step();
    rst = 0; bus.if_req = 1;
    @(negedge clk);
    chk("t5_regrant", 32'(bus.if_gnt), 32'd1);
    chk("t5_rdata_cleared", bus.if_rdata, 32'h0);
    step();
    bus.if_req = 0;

    // Data request raised during RD_I then withdrawn before IDLE.
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h3C; bus.d_wdata = 32'hFFFF_FFFF; bus.d_wstrb = 4'hF;
    step();
    bus.d_req = 0;
    @(negedge clk);
    chk("t6_no_gnt", 32'({bus.d_gnt, bus.mem_en}), 32'h0);
    step();

    // Randomised traffic with occasional resets and withdrawals.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ig = bus.if_gnt;
      dg = bus.d_gnt;
      step();
      rst = ($urandom_range(0, 199) == 0);
      if (bus.if_req && !ig) begin
        if ($urandom_range(0, 9) == 0) bus.if_req = 0;
      end else begin
        bus.if_req = 1'($urandom_range(0, 1));
        bus.if_addr = 8'($urandom);
      end
      if (bus.d_req && !dg) begin
        if ($urandom_range(0, 9) == 0) bus.d_req = 0;
      end else begin
        bus.d_req = 1'($urandom_range(0, 1));
        bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = 8'($urandom);
        bus.d_wdata = $urandom;
        bus.d_wstrb = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      end
    end
    step();
    rst = 0; bus.if_req = 0; bus.d_req = 0;
    repeat (4) step();
    chk("drain_ifq", 32'(ifq.size()), 32'd0);
    chk("drain_dq", 32'(dq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
